// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman affine-gap processing element:
// score range limits, stream FSM encoding and residue codes.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } sw_state_t;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int unsigned AA_COUNT = 20;
  localparam logic [4:0]  AA_ANY   = 5'd20;

  function automatic int neg_inf(input int unsigned w);
    return -(2 ** (w - 1));
  endfunction

  function automatic int pos_max(input int unsigned w);
    return (2 ** (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sw_sat_addsub.sv
// Signed add/subtract clamped to the representable score range.
module sw_sat_addsub
  import sw_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-1:0] y
);

  logic signed [W:0] wide;

  always_comb begin
    wide = sub ? ({a[W-1], a} - {b[W-1], b}) : ({a[W-1], a} + {b[W-1], b});
    if (wide[W] != wide[W-1]) begin
      y = wide[W] ? W'(neg_inf(W)) : W'(pos_max(W));
    end else begin
      y = wide[W-1:0];
    end
  end

endmodule

// File: rtl/sw_pe_affine.sv
// Systolic Smith-Waterman/Needleman-Wunsch processing element with affine gaps:
// one query symbol, one target element per enabled cycle, running best tracking.
module sw_pe_affine
  import sw_pkg::*;
#(
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned BASE_WIDTH  = 2,
  parameter int unsigned COL_WIDTH   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          q_load,
  input  logic [BASE_WIDTH-1:0]         q_in,
  output logic [BASE_WIDTH-1:0]         q_out,
  input  logic                          global_mode,
  input  logic signed [SCORE_WIDTH-1:0] sub_match,
  input  logic signed [SCORE_WIDTH-1:0] sub_mismatch,
  input  logic [SCORE_WIDTH-2:0]        gap_open,
  input  logic [SCORE_WIDTH-2:0]        gap_extend,
  input  logic signed [SCORE_WIDTH-1:0] h_col0,
  input  logic signed [SCORE_WIDTH-1:0] h_diag0,
  input  logic                          en_in,
  output logic                          en_out,
  input  logic [BASE_WIDTH-1:0]         base_in,
  output logic [BASE_WIDTH-1:0]         base_out,
  input  logic signed [SCORE_WIDTH-1:0] H_in,
  input  logic signed [SCORE_WIDTH-1:0] F_in,
  output logic signed [SCORE_WIDTH-1:0] H_out,
  output logic signed [SCORE_WIDTH-1:0] F_out,
  input  logic signed [SCORE_WIDTH-1:0] high_in,
  input  logic [COL_WIDTH-1:0]          high_col_in,
  output logic signed [SCORE_WIDTH-1:0] high_out,
  output logic [COL_WIDTH-1:0]          high_col_out,
  output logic                          vld
);

  localparam logic signed [SCORE_WIDTH-1:0] NEG_INF = SCORE_WIDTH'(neg_inf(SCORE_WIDTH));

  sw_state_t                     state;
  logic [BASE_WIDTH-1:0]         q;
  logic                          gmode_r;
  logic signed [SCORE_WIDTH-1:0] hdiag_r, h_prev_r, e_prev_r, best_r;
  logic [COL_WIDTH-1:0]          col, best_col_r;

  logic                          first, mode;
  logic signed [SCORE_WIDTH-1:0] hdiag, hprev, eprev, s_val, go_s, ge_s;
  logic signed [SCORE_WIDTH-1:0] m_val, e_t, e_open, e_ext, f_t, f_open, f_ext;
  logic signed [SCORE_WIDTH-1:0] e_val, f_val, h_raw, h_val, best_n;
  logic [COL_WIDTH-1:0]          col_next, best_col_n;
  logic                          best_upd;

  assign first = en_in && (state != ST_RUN);
  assign mode  = first ? global_mode : gmode_r;
  assign hdiag = first ? h_diag0 : hdiag_r;
  assign hprev = first ? h_col0 : h_prev_r;
  assign eprev = first ? NEG_INF : e_prev_r;
  assign s_val = (base_in == q) ? sub_match : sub_mismatch;
  assign go_s  = {1'b0, gap_open};
  assign ge_s  = {1'b0, gap_extend};

  // go+ge may exceed the score range, so open penalties are applied as two
  // saturating steps; the clamped result equals clamping the exact sum.
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_m    (.a(hdiag),    .b(s_val), .sub(1'b0), .y(m_val));
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_eo1  (.a(hprev),    .b(go_s),  .sub(1'b1), .y(e_t));
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_eo2  (.a(e_t),      .b(ge_s),  .sub(1'b1), .y(e_open));
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_ex   (.a(eprev),    .b(ge_s),  .sub(1'b1), .y(e_ext));
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_fo1  (.a(H_in),     .b(go_s),  .sub(1'b1), .y(f_t));
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_fo2  (.a(f_t),      .b(ge_s),  .sub(1'b1), .y(f_open));
  sw_sat_addsub #(.W(SCORE_WIDTH)) u_fx   (.a(F_in),     .b(ge_s),  .sub(1'b1), .y(f_ext));

  always_comb begin
    e_val = (e_open > e_ext) ? e_open : e_ext;
    f_val = (f_open > f_ext) ? f_open : f_ext;
    h_raw = m_val;
    if (e_val > h_raw) h_raw = e_val;
    if (f_val > h_raw) h_raw = f_val;
    h_val = (!mode && h_raw < 0) ? '0 : h_raw;

    col_next   = first ? COL_WIDTH'(1) : ((&col) ? col : col + 1'b1);
    best_upd   = first || (h_val > best_r);
    best_n     = best_upd ? h_val : best_r;
    best_col_n = best_upd ? col_next : best_col_r;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      q            <= '0;
      q_out        <= '0;
      gmode_r      <= 1'b0;
      en_out       <= 1'b0;
      vld          <= 1'b0;
      base_out     <= '0;
      H_out        <= '0;
      F_out        <= NEG_INF;
      high_out     <= '0;
      high_col_out <= '0;
      col          <= '0;
      best_r       <= '0;
      best_col_r   <= '0;
      hdiag_r      <= '0;
      h_prev_r     <= '0;
      e_prev_r     <= NEG_INF;
    end else begin
      vld    <= 1'b0;
      en_out <= en_in;
      case (state)
        ST_IDLE: if (en_in) state <= ST_RUN;
        ST_RUN:  if (!en_in) begin
                   state <= ST_DONE;
                   vld   <= 1'b1;
                 end
        ST_DONE: state <= en_in ? ST_RUN : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (first) gmode_r <= global_mode;
      if (state == ST_IDLE && q_load) begin
        q     <= q_in;
        q_out <= q;
      end
      if (en_in) begin
        base_out   <= base_in;
        H_out      <= h_val;
        F_out      <= f_val;
        hdiag_r    <= H_in;
        h_prev_r   <= h_val;
        e_prev_r   <= e_val;
        col        <= col_next;
        best_r     <= best_n;
        best_col_r <= best_col_n;
        if (high_in >= best_n) begin
          high_out     <= high_in;
          high_col_out <= high_col_in;
        end else begin
          high_out     <= best_n;
          high_col_out <= best_col_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_pe_affine.sv
// Scoreboard bench for sw_pe_affine: a per-stream reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_sw_pe_affine;
  import sw_pkg::*;

  localparam int SW   = 8;
  localparam int BW   = 2;
  localparam int CW   = 3;
  localparam int NEG  = -128;
  localparam int PMAX = 127;
  localparam int CMAX = 7;

  logic                 clk = 1'b0;
  logic                 rst, q_load, global_mode, en_in, en_out, vld;
  logic [BW-1:0]        q_in, q_out, base_in, base_out;
  logic signed [SW-1:0] sub_match, sub_mismatch, h_col0, h_diag0;
  logic [SW-2:0]        gap_open, gap_extend;
  logic signed [SW-1:0] H_in, F_in, H_out, F_out, high_in, high_out;
  logic [CW-1:0]        high_col_in, high_col_out;

  sw_pe_affine #(.SCORE_WIDTH(SW), .BASE_WIDTH(BW), .COL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .q_load(q_load), .q_in(q_in), .q_out(q_out),
    .global_mode(global_mode), .sub_match(sub_match), .sub_mismatch(sub_mismatch),
    .gap_open(gap_open), .gap_extend(gap_extend), .h_col0(h_col0), .h_diag0(h_diag0),
    .en_in(en_in), .en_out(en_out), .base_in(base_in), .base_out(base_out),
    .H_in(H_in), .F_in(F_in), .H_out(H_out), .F_out(F_out),
    .high_in(high_in), .high_col_in(high_col_in), .high_out(high_out),
    .high_col_out(high_col_out), .vld(vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_vld;
    int h, f, base, high, hcol;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;
  int   tests = 0;
  int   fails = 0;

  int s_base[16], s_hin[16], s_fin[16], s_hi[16], s_hic[16];
  int s_match, s_mis, s_go, s_ge, s_hcol0, s_hdiag0, mq;
  bit s_mode, s_qload_run;

  function automatic int sat(input int x);
    return (x < NEG) ? NEG : ((x > PMAX) ? PMAX : x);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int rnd_score();
    case ($urandom_range(0, 7))
      0:       return NEG;
      1:       return PMAX;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en_out || vld) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", int'({en_out, vld}), 0);
      end else begin
        ex = sbq.pop_front();
        check("output_kind", int'(vld), int'(ex.is_vld));
        check("high_out", int'(high_out), ex.high);
        check("high_col_out", int'(high_col_out), ex.hcol);
        if (!ex.is_vld) begin
          check("H_out", int'(H_out), ex.h);
          check("F_out", int'(F_out), ex.f);
          check("base_out", int'(base_out), ex.base);
        end
      end
    end
  end

  task automatic fill_random(input int n);
    s_match  = int'($urandom_range(0, 12));
    s_mis    = -int'($urandom_range(0, 12));
    s_go     = int'($urandom_range(0, 40));
    s_ge     = int'($urandom_range(0, 20));
    s_mode   = 1'($urandom_range(0, 1));
    s_hcol0  = rnd_score();
    s_hdiag0 = rnd_score();
    for (int k = 0; k < n; k++) begin
      s_base[k] = int'($urandom_range(0, 3));
      s_hin[k]  = rnd_score();
      s_fin[k]  = rnd_score();
      s_hi[k]   = rnd_score();
      s_hic[k]  = int'($urandom_range(0, CMAX));
    end
  endtask

  task automatic drive_stream(input int n, input int gap, input int abort_at);
    int hdiag, hprev, eprev, best, bcol, col, s, m, e, f, h, hi_v, hic_v;
    exp_t x;
    sub_match    = SW'(s_match);
    sub_mismatch = SW'(s_mis);
    gap_open     = (SW-1)'(s_go);
    gap_extend   = (SW-1)'(s_ge);
    for (int k = 0; k < n; k++) begin
      en_in       = 1'b1;
      base_in     = BW'(s_base[k]);
      H_in        = SW'(s_hin[k]);
      F_in        = SW'(s_fin[k]);
      high_in     = SW'(s_hi[k]);
      high_col_in = CW'(s_hic[k]);
      global_mode = (k == 0) ? s_mode : 1'($urandom_range(0, 1));
      h_col0      = (k == 0) ? SW'(s_hcol0) : SW'(rnd_score());
      h_diag0     = (k == 0) ? SW'(s_hdiag0) : SW'(rnd_score());
      q_load      = s_qload_run && (k > 0);
      q_in        = BASE_G;
      if (k == abort_at) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b1;
        en_in  = 1'b0;
        q_load = 1'b0;
        mq     = 0;
        return;
      end
      if (k == 0) begin
        hdiag = s_hdiag0; hprev = s_hcol0; eprev = NEG; col = 1;
      end else begin
        col = (col < CMAX) ? col + 1 : CMAX;
      end
      s = (s_base[k] == mq) ? s_match : s_mis;
      m = sat(hdiag + s);
      e = imax(sat(hprev - s_go - s_ge), sat(eprev - s_ge));
      f = imax(sat(s_hin[k] - s_go - s_ge), sat(s_fin[k] - s_ge));
      h = imax(m, imax(e, f));
      if (!s_mode) h = imax(h, 0);
      if (k == 0 || h > best) begin
        best = h; bcol = col;
      end
      if (s_hi[k] >= best) begin
        hi_v = s_hi[k]; hic_v = s_hic[k];
      end else begin
        hi_v = best; hic_v = bcol;
      end
      x = '{is_vld: 1'b0, h: h, f: f, base: s_base[k], high: hi_v, hcol: hic_v};
      sbq.push_back(x);
      hdiag = s_hin[k]; hprev = h; eprev = e;
      @(posedge clk); #1;
    end
    en_in = 1'b0;
    x = '{is_vld: 1'b1, h: 0, f: 0, base: 0, high: hi_v, hcol: hic_v};
    sbq.push_back(x);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    q_load = 1'b0;
  endtask

  task automatic set_directed(input int n, input int base0, input int hin, input int fin);
    for (int k = 0; k < n; k++) begin
      s_base[k] = base0; s_hin[k] = hin; s_fin[k] = fin; s_hi[k] = NEG; s_hic[k] = 0;
    end
  endtask

  initial begin
    rst = 1'b0; q_load = 1'b0; q_in = '0; global_mode = 1'b0; en_in = 1'b0;
    base_in = '0; H_in = '0; F_in = '0; high_in = '0; high_col_in = '0;
    sub_match = '0; sub_mismatch = '0; gap_open = '0; gap_extend = '0;
    h_col0 = '0; h_diag0 = '0; s_qload_run = 1'b0; mq = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en_out", int'(en_out), 0);
    check("rst_vld", int'(vld), 0);
    check("rst_H_out", int'(H_out), 0);
    check("rst_F_out", int'(F_out), NEG);
    check("rst_high_col_out", int'(high_col_out), 0);
    check("rst_q_out", int'(q_out), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Local, query A, target A,A,G,A
    s_mode = 1'b0; s_match = 2; s_mis = -1; s_go = 3; s_ge = 1; s_hcol0 = 0; s_hdiag0 = 0;
    set_directed(4, BASE_A, 0, NEG);
    s_base[2] = BASE_G;
    drive_stream(4, 2, -1);

    // Global vs local on a single mismatch
    s_mode = 1'b1; s_hcol0 = -4; s_hdiag0 = 0;
    set_directed(1, BASE_G, -4, NEG);
    drive_stream(1, 2, -1);
    s_mode = 1'b0;
    drive_stream(1, 2, -1);

    // Saturation at the top of the score range, then a back-to-back stream
    s_hcol0 = 0; s_hdiag0 = 0;
    set_directed(2, BASE_A, 126, NEG);
    drive_stream(2, 1, -1);
    fill_random(5);
    drive_stream(5, 2, -1);

    // Query loading in IDLE, then ignored in RUN/DONE
    q_load = 1'b1; q_in = BASE_C;
    @(posedge clk); #1;
    q_in = BASE_T;
    @(posedge clk); #1;
    q_load = 1'b0;
    check("q_out_after_load", int'(q_out), int'(BASE_C));
    mq = BASE_T;
    fill_random(6);
    s_qload_run = 1'b1;
    drive_stream(6, 2, -1);
    s_qload_run = 1'b0;
    check("q_out_after_run_load", int'(q_out), int'(BASE_C));
    fill_random(6);
    drive_stream(6, 2, -1);

    // Reset during the second element
    fill_random(4);
    drive_stream(4, 0, 1);
    check("abort_en_out", int'(en_out), 0);
    check("abort_vld", int'(vld), 0);
    check("abort_H_out", int'(H_out), 0);
    check("abort_F_out", int'(F_out), NEG);
    check("abort_high_out", int'(high_out), 0);
    check("abort_high_col_out", int'(high_col_out), 0);
    check("abort_base_out", int'(base_out), 0);
    check("abort_q_out", int'(q_out), 0);
    repeat (3) @(posedge clk);
    #1;
    fill_random(3);
    for (int k = 0; k < 3; k++) s_hi[k] = NEG;
    drive_stream(3, 2, -1);

    // Column counter saturation
    fill_random(11);
    drive_stream(11, 2, -1);

    for (int i = 0; i < 30; i++) begin
      fill_random(16);
      drive_stream(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)), -1);
    end

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_pe_affine.md
SW_PE_AFFINE -- requirements
Module: sw_pe_affine

Interface
REQ-001 Parameter SCORE_WIDTH, default 12: signed two's-complement score width.
REQ-002 Parameter BASE_WIDTH, default 2: symbol width; 2 = DNA, 5 = protein.
REQ-003 Parameter COL_WIDTH, default 10: target column counter width.
REQ-004 Ports clk (in, 1, clock) and rst (in, 1, reset); reset rst is synchronous and active-low, clock clk.
REQ-005 Port q_load, in, 1: shift q_in into the query register.
REQ-006 Port q_in / q_out, in / out, BASE_WIDTH: query shift-chain input and output.
REQ-007 Port global_mode, in, 1: 0 = local, 1 = global alignment.
REQ-008 Ports sub_match and sub_mismatch, in, SCORE_WIDTH, signed: substitution scores.
REQ-009 Ports gap_open and gap_extend, in, SCORE_WIDTH-1, unsigned: penalty magnitudes (go, ge).
REQ-010 Ports h_col0 and h_diag0, in, SCORE_WIDTH, signed: boundary values H(i,0) and H(i-1,0).
REQ-011 Ports en_in / en_out, in / out, 1: stream element valid from left / to right.
REQ-012 Ports base_in / base_out, in / out, BASE_WIDTH: target symbol in and forwarded.
REQ-013 Ports H_in, F_in / H_out, F_out, in / out, SCORE_WIDTH: H and vertical-gap F scores, left to right.
REQ-014 Ports high_in, high_col_in / high_out, high_col_out, in / out, SCORE_WIDTH / COL_WIDTH: best score and its column.
REQ-015 Port vld, out, 1: one-cycle pulse marking high_out and high_col_out final.

Function
REQ-016 Recurrence per element j, with q = query register:
- s = sub_match if base_in == q, else sub_mismatch
- M = Hdiag + s
- E = max(Hprev - go - ge, Eprev - ge)
- F = max(H_in - go - ge, F_in - ge)
- H = max(M, E, F), and additionally max(.., 0) in local mode.
REQ-017 Hdiag is the H_in registered on the previous element; Hprev and Eprev are this PE's own previous H and E.
REQ-018 On the first element of a stream (en_in rises from 0), boundary values SHALL be used:
- Hdiag = h_diag0
- Hprev = h_col0
- Eprev = NEG_INF.
REQ-019 All additions and subtractions SHALL saturate to [NEG_INF, POS_MAX] (most-negative value, most-positive value) and never wrap.
REQ-020 Latency is 1 cycle: H_out, F_out, base_out and en_out SHALL register the element presented with en_in=1.
REQ-021 With en_in=0, en_out SHALL be 0 and H_out, F_out and base_out SHALL hold their values.
REQ-022 Stream FSM states:
- IDLE -> RUN on en_in=1
- RUN -> DONE on en_in=0
- DONE -> IDLE unconditionally, or -> RUN if en_in=1.
REQ-023 global_mode SHALL be sampled on the IDLE/DONE->RUN transition; mid-stream changes are ignored.
REQ-024 Column counter SHALL be 1 on the first element of a stream and increment per element; it SHALL saturate at all-ones.
REQ-025 Running best SHALL be replaced only when the own H is strictly greater, so ties keep the earlier column.
REQ-026 high_out SHALL be max(high_in, own best); on equality, high_in and high_col_in win.
REQ-027 high_out and high_col_out SHALL update every RUN cycle and hold from DONE until the next stream start.
REQ-028 vld SHALL be 1 for exactly the one DONE cycle.
REQ-029 q_load SHALL load q_in into q and move the old q to q_out, taking effect only in IDLE; q_load in RUN or DONE is ignored.

Reset
REQ-030 On rst=0 at a clock edge, the following SHALL be reset:
- en_out, vld, q, q_out, base_out: 0
- H_out, high_out: 0
- F_out: NEG_INF
- high_col_out, counter: 0
- FSM: IDLE.
REQ-031 Reset mid-stream SHALL abort the stream with no vld pulse; processing resumes on en_in after rst=1.

Structure
REQ-032 A shared package sw_pkg SHALL hold NEG_INF/POS_MAX functions of SCORE_WIDTH, the FSM state encoding and the DNA/protein base codes.
REQ-033 One sub-module, sw_sat_addsub (saturating signed add/subtract), SHALL be instantiated for every arithmetic term.

Verification
REQ-034 Local mode, query A, target A,A,G,A, H_in=0, F_in=NEG_INF, match=+2, mismatch=-1, go=3, ge=1, h_col0=h_diag0=0 -> H_out 2,2,0,2 one cycle after each element; vld pulse with high_out=2, high_col_out=1.
REQ-035 SCORE_WIDTH=8, H_in=126 for two elements, both matches (+2) -> second H_out=127 (saturated, no wrap).
REQ-036 Global mode, query A, target G, H_in=-4, F_in=NEG_INF, h_diag0=0, h_col0=-4 -> H_out=-1 (in local mode the same stimulus gives 0).
REQ-037 q_load with C then T in IDLE -> q=T, q_out=C; q_load asserted during RUN -> q unchanged.
REQ-038 rst=0 during the 2nd element of a 4-element stream -> next cycle all outputs at reset values, no vld pulse; a new stream afterwards starts at column 1.
REQ-039 Two streams separated by one idle cycle -> vld after each, with column and E restarted from the boundary; the second stream's high is independent of the first.
